multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle main decoder: sequences each MIPS instruction through fetch, decode, execute, memory and writeback states.
- Drives shared-datapath controls: one ALU, one unified memory, IR/PC write enables.
- Adds ADDI support, variable-latency memory via a MemReady handshake, a memory timeout, and illegal-opcode exception reporting.
- Sits between the instruction register (Op source) and the multi-cycle datapath.

Parameters:
- OP_WIDTH, 6, opcode width.
- ENABLE_ADDI, 1, decode ADDI (op 001000); when 0, ADDI is illegal.
- MEM_TIMEOUT, 16, max cycles waiting for MemReady in a memory state; 0 disables the timeout.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Op  input  OP_WIDTH  opcode from the IR; stable from DECODE until the instruction ends.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegWrite, RegDst, ALUSrcA  output  1  datapath controls.
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  output  2  00 add, 01 sub, 10 funct-decoded.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
- InstrDone  output  1  one-cycle pulse in the final cycle of each instruction.
- Exception  output  1  one-cycle pulse on illegal opcode or memory timeout.
- State  output  4  current state encoding (debug).

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Codes 12-15: next state FETCH, all outputs 0.
- Reset (asynchronous, any time, including mid-instruction):
  - State=FETCH; timeout counter=0.
  - While Reset=1, all control outputs, InstrDone and Exception are forced 0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Next: DECODE when MemReady=1; otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next by Op: 000000 EXECUTE; 100011/101011 MEMADR; 000100 BRANCH; 000010 JUMP; 001000 ADDIEX (only if ENABLE_ADDI).
  - Any other opcode: Exception=1 this cycle, next FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if Op=LW, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Next MEMWB when MemReady=1.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, InstrDone=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. InstrDone=MemReady. Next FETCH when MemReady=1.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegDst=1, RegWrite=1, MemToReg=0, InstrDone=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, InstrDone=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1, MemToReg=0, InstrDone=1. Next FETCH.
- Timeout (applies in FETCH, MEMRD, MEMWR):
  - Counter increments each cycle MemReady=0; clears on MemReady=1 or on leaving the state.
  - When the counter reaches MEM_TIMEOUT-1 with MemReady=0: Exception=1, all write enables 0, next FETCH, counter cleared.
  - MemReady=1 in that same cycle wins: normal completion, no Exception.
- Zero-wait latency in cycles: BEQ/J 3, R-type/SW/ADDI 4, LW 5.

Decomposition:
- Shared package mips_ctrl_pkg: opcode constants (R, LW, SW, BEQ, J, ADDI), state enum/encodings, ALUOp/ALUSrcB/PCSource codes. The ALU control unit uses the same package.
- Sub-module mem_wait_timer: parametrised timeout counter (inputs: count enable, clear; output: expired).
- Next-state and output decode stay in this module.

Test Plan:
- R-type, MemReady tied 1: Op=000000 → states 0,1,6,7,0. ALUOp=10 in state 6; RegDst=RegWrite=InstrDone=1 in state 7.
- LW with 3 wait cycles in MEMRD: Op=100011 → MEMRD holds 4 cycles with MemRead=IorD=1. MEMWB then has MemToReg=RegWrite=1. Total 8 cycles, one InstrDone.
- BEQ then J: BEQ gives PCWriteCond=1, PCSource=01, ALUOp=01 in state 8. J gives PCWrite=1, PCSource=10 in state 9. Each takes 3 cycles.
- Illegal op 111111, and ADDI with ENABLE_ADDI=0 → Exception pulse in DECODE, no RegWrite/MemWrite, next state FETCH. With ENABLE_ADDI=1, ADDI → states 10,11 and RegWrite=1.
- MemReady held 0 in MEMWR, MEM_TIMEOUT=4 → Exception on the 4th cycle, MemWrite deasserted next cycle, State=0. MemReady=1 on the 4th cycle → InstrDone, no Exception.
- Reset asserted in MEMRD → outputs 0 immediately (asynchronous), State=0. After release, FETCH resumes with MemRead=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle controller and the ALU control unit:
// opcodes, FSM state encodings and datapath mux/ALU select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       exception;
  } ctrl_t;

  // States that wait on the memory handshake and are therefore guarded by the timeout.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting for MemReady; expired_o marks the last
// cycle allowed before a timeout. MEM_TIMEOUT of 0 disables the timer.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int          CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          ENABLED = (MEM_TIMEOUT > 0);
  localparam logic [CW-1:0] LAST  = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [CW-1:0] count_q;

  // Wait counter; clear has priority so a completed or abandoned wait never carries over.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i || !ENABLED) begin
      count_q <= '0;
    end else if (cnt_en_i) begin
      count_q <= count_q + CW'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign expired_o = ENABLED && (count_q == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/writeback,
// waits on MemReady with a timeout, and flags illegal opcodes.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OP_WIDTH-1:0] Op,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                InstrDone,
  output logic                Exception,
  output logic [3:0]          State
);

  localparam logic [OP_WIDTH-1:0] OPW_RTYPE = OP_WIDTH'(OP_RTYPE);
  localparam logic [OP_WIDTH-1:0] OPW_LW    = OP_WIDTH'(OP_LW);
  localparam logic [OP_WIDTH-1:0] OPW_SW    = OP_WIDTH'(OP_SW);
  localparam logic [OP_WIDTH-1:0] OPW_BEQ   = OP_WIDTH'(OP_BEQ);
  localparam logic [OP_WIDTH-1:0] OPW_J     = OP_WIDTH'(OP_J);
  localparam logic [OP_WIDTH-1:0] OPW_ADDI  = OP_WIDTH'(OP_ADDI);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;
  logic   wait_s;
  logic   expired_s;
  logic   timeout_s;
  logic   cnt_en_s;
  logic   clr_s;

  assign wait_s    = is_mem_wait(state_q);
  assign timeout_s = wait_s && !MemReady && expired_s;
  assign cnt_en_s  = wait_s && !MemReady;
  // A timeout also clears, so the next wait state starts counting from zero.
  assign clr_s     = !wait_s || MemReady || expired_s;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .cnt_en_i (cnt_en_s),
    .clr_i    (clr_s),
    .expired_o(expired_s)
  );

  // Next-state and control decode from the current state, opcode and memory handshake.
  always_comb begin
    ctrl_s  = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_source = PCSRC_ALU;
        if (MemReady) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
          state_d         = S_DECODE;
        end else if (timeout_s) begin
          ctrl_s.exception = 1'b1;
          state_d          = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl_s.alu_src_b = SRCB_IMM_SH2;
        ctrl_s.alu_op    = ALUOP_ADD;
        if (Op == OPW_RTYPE) begin
          state_d = S_EXECUTE;
        end else if ((Op == OPW_LW) || (Op == OPW_SW)) begin
          state_d = S_MEMADR;
        end else if (Op == OPW_BEQ) begin
          state_d = S_BRANCH;
        end else if (Op == OPW_J) begin
          state_d = S_JUMP;
        end else if (ENABLE_ADDI && (Op == OPW_ADDI)) begin
          state_d = S_ADDIEX;
        end else begin
          ctrl_s.exception = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_MEMADR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
        if (Op == OPW_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.iord     = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else if (timeout_s) begin
          ctrl_s.exception = 1'b1;
          state_d          = S_FETCH;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_s.iord = 1'b1;
        // On timeout the store is dropped rather than left hanging on the bus.
        if (MemReady) begin
          ctrl_s.mem_write  = 1'b1;
          ctrl_s.instr_done = 1'b1;
          state_d           = S_FETCH;
        end else if (timeout_s) begin
          ctrl_s.exception = 1'b1;
          state_d          = S_FETCH;
        end else begin
          ctrl_s.mem_write = 1'b1;
          state_d          = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_REGB;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        state_d          = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_src_b     = SRCB_REGB;
        ctrl_s.alu_op        = ALUOP_SUB;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = PCSRC_ALUOUT;
        ctrl_s.instr_done    = 1'b1;
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.pc_source  = PCSRC_JUMP;
        ctrl_s.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
        state_d          = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
        state_d           = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register; reset returns to FETCH from anywhere, mid-instruction included.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl_out_s  = Reset ? '0 : ctrl_s;

  assign PCWrite     = ctrl_out_s.pc_write;
  assign PCWriteCond = ctrl_out_s.pc_write_cond;
  assign IorD        = ctrl_out_s.iord;
  assign MemRead     = ctrl_out_s.mem_read;
  assign MemWrite    = ctrl_out_s.mem_write;
  assign IRWrite     = ctrl_out_s.ir_write;
  assign MemToReg    = ctrl_out_s.mem_to_reg;
  assign RegWrite    = ctrl_out_s.reg_write;
  assign RegDst      = ctrl_out_s.reg_dst;
  assign ALUSrcA     = ctrl_out_s.alu_src_a;
  assign ALUSrcB     = ctrl_out_s.alu_src_b;
  assign ALUOp       = ctrl_out_s.alu_op;
  assign PCSource    = ctrl_out_s.pc_source;
  assign InstrDone   = ctrl_out_s.instr_done;
  assign Exception   = ctrl_out_s.exception;
  assign State       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: the driver queues per-cycle expected
// state/control vectors, the monitor pops and compares them on the falling edge.
module tb_multicycle_control_fsm;

  // Vector bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg
  // RegWrite RegDst ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] InstrDone Exception
  localparam logic [17:0] V_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_FETCH_GO   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_FETCH_TMO  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_1;
  localparam logic [17:0] V_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] V_DECODE_EXC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] V_MEMADR     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_MEMRD      = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MEMWB      = 18'b0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR_WAIT = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MEMWR_DONE = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR_TMO  = 18'b0_0_1_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] V_EXECUTE    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] V_ALUWB      = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] V_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] V_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] V_ADDIEX     = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_ADDIWB     = 18'b0_0_0_0_0_0_0_1_0_0_00_00_00_1_0;
  localparam logic [17:0] M_ALL        = 18'h3FFFF;
  localparam logic [17:0] M_NO_MW      = 18'h3DFFF;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    string       nm;
    logic [3:0]  s1;
    logic [17:0] v1;
    logic [3:0]  s2;
    logic [17:0] v2;
    logic [17:0] m;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic [5:0] Op;
  logic       MemReady;
  wire [17:0] act1;
  wire [17:0] act2;
  wire [3:0]  st1;
  wire [3:0]  st2;

  exp_t sb[$];
  bit   stim_done = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  multicycle_control_fsm #(.OP_WIDTH(6), .ENABLE_ADDI(1'b1), .MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(act1[17]), .PCWriteCond(act1[16]), .IorD(act1[15]), .MemRead(act1[14]),
    .MemWrite(act1[13]), .IRWrite(act1[12]), .MemToReg(act1[11]), .RegWrite(act1[10]),
    .RegDst(act1[9]), .ALUSrcA(act1[8]), .ALUSrcB(act1[7:6]), .ALUOp(act1[5:4]),
    .PCSource(act1[3:2]), .InstrDone(act1[1]), .Exception(act1[0]), .State(st1)
  );

  multicycle_control_fsm #(.OP_WIDTH(6), .ENABLE_ADDI(1'b0), .MEM_TIMEOUT(4)) dut_noaddi (
    .Clk(Clk), .Reset(Reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(act2[17]), .PCWriteCond(act2[16]), .IorD(act2[15]), .MemRead(act2[14]),
    .MemWrite(act2[13]), .IRWrite(act2[12]), .MemToReg(act2[11]), .RegWrite(act2[10]),
    .RegDst(act2[9]), .ALUSrcA(act2[8]), .ALUSrcB(act2[7:6]), .ALUOp(act2[5:4]),
    .PCSource(act2[3:2]), .InstrDone(act2[1]), .Exception(act2[0]), .State(st2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp,
                     input logic [17:0] m);
    n_tests++;
    if ((act & m) !== (exp & m)) begin
      n_fail++;
      $display("FAIL %s got %b want %b (mask %b)", nm, act, exp, m);
    end
  endtask

  task automatic cyc_full(input string nm, input logic rst, input logic [5:0] op,
                          input logic mr, input logic [3:0] s1, input logic [17:0] v1,
                          input logic [3:0] s2, input logic [17:0] v2, input logic [17:0] m);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset    = rst;
    Op       = op;
    MemReady = mr;
    e.nm = nm; e.s1 = s1; e.v1 = v1; e.s2 = s2; e.v2 = v2; e.m = m;
    sb.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] s, input logic [17:0] v);
    cyc_full(nm, rst, op, mr, s, v, s, v, M_ALL);
  endtask

  // Driver: inputs change 1 ns after the rising edge, expectations hold for that cycle.
  initial begin
    Reset = 1'b1; Op = OP_R; MemReady = 1'b0;
    cyc("reset_a", 1'b1, OP_R, 1'b0, 4'd0, V_ZERO);
    cyc("reset_b", 1'b1, OP_R, 1'b1, 4'd0, V_ZERO);
    // R-type, zero wait
    cyc("r_fetch",  1'b0, OP_R, 1'b1, 4'd0, V_FETCH_GO);
    cyc("r_decode", 1'b0, OP_R, 1'b1, 4'd1, V_DECODE);
    cyc("r_exec",   1'b0, OP_R, 1'b1, 4'd6, V_EXECUTE);
    cyc("r_wb",     1'b0, OP_R, 1'b1, 4'd7, V_ALUWB);
    // LW with three wait cycles; ready arrives on the last allowed cycle
    cyc("lw_fetch",  1'b0, OP_LW, 1'b1, 4'd0, V_FETCH_GO);
    cyc("lw_decode", 1'b0, OP_LW, 1'b1, 4'd1, V_DECODE);
    cyc("lw_adr",    1'b0, OP_LW, 1'b0, 4'd2, V_MEMADR);
    cyc("lw_rd0",    1'b0, OP_LW, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_rd1",    1'b0, OP_LW, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_rd2",    1'b0, OP_LW, 1'b0, 4'd3, V_MEMRD);
    cyc("lw_rd3",    1'b0, OP_LW, 1'b1, 4'd3, V_MEMRD);
    cyc("lw_wb",     1'b0, OP_LW, 1'b1, 4'd4, V_MEMWB);
    // BEQ then J
    cyc("beq_fetch",  1'b0, OP_BEQ, 1'b1, 4'd0, V_FETCH_GO);
    cyc("beq_decode", 1'b0, OP_BEQ, 1'b1, 4'd1, V_DECODE);
    cyc("beq_br",     1'b0, OP_BEQ, 1'b1, 4'd8, V_BRANCH);
    cyc("j_fetch",    1'b0, OP_J,   1'b1, 4'd0, V_FETCH_GO);
    cyc("j_decode",   1'b0, OP_J,   1'b1, 4'd1, V_DECODE);
    cyc("j_jump",     1'b0, OP_J,   1'b1, 4'd9, V_JUMP);
    // SW, zero wait
    cyc("sw_fetch",  1'b0, OP_SW, 1'b1, 4'd0, V_FETCH_GO);
    cyc("sw_decode", 1'b0, OP_SW, 1'b1, 4'd1, V_DECODE);
    cyc("sw_adr",    1'b0, OP_SW, 1'b1, 4'd2, V_MEMADR);
    cyc("sw_wr",     1'b0, OP_SW, 1'b1, 4'd5, V_MEMWR_DONE);
    // Illegal opcode
    cyc("ill_fetch",  1'b0, OP_BAD, 1'b1, 4'd0, V_FETCH_GO);
    cyc("ill_decode", 1'b0, OP_BAD, 1'b1, 4'd1, V_DECODE_EXC);
    // ADDI: legal in dut, illegal in dut_noaddi (which refetches and faults again)
    cyc("addi_fetch", 1'b0, OP_ADDI, 1'b1, 4'd0, V_FETCH_GO);
    cyc_full("addi_decode", 1'b0, OP_ADDI, 1'b1, 4'd1,  V_DECODE, 4'd1, V_DECODE_EXC, M_ALL);
    cyc_full("addi_ex",     1'b0, OP_ADDI, 1'b1, 4'd10, V_ADDIEX, 4'd0, V_FETCH_GO,   M_ALL);
    cyc_full("addi_wb",     1'b0, OP_ADDI, 1'b1, 4'd11, V_ADDIWB, 4'd1, V_DECODE_EXC, M_ALL);
    // SW timeout in MEMWR
    cyc("swt_fetch",  1'b0, OP_SW, 1'b1, 4'd0, V_FETCH_GO);
    cyc("swt_decode", 1'b0, OP_SW, 1'b1, 4'd1, V_DECODE);
    cyc("swt_adr",    1'b0, OP_SW, 1'b0, 4'd2, V_MEMADR);
    cyc("swt_wr0",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc("swt_wr1",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc("swt_wr2",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc_full("swt_tmo", 1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_TMO, 4'd5, V_MEMWR_TMO, M_NO_MW);
    // Back in FETCH with MemWrite low; FETCH then times out as well
    cyc("ft0", 1'b0, OP_SW, 1'b0, 4'd0, V_FETCH_WAIT);
    cyc("ft1", 1'b0, OP_SW, 1'b0, 4'd0, V_FETCH_WAIT);
    cyc("ft2", 1'b0, OP_SW, 1'b0, 4'd0, V_FETCH_WAIT);
    cyc("ft3", 1'b0, OP_SW, 1'b0, 4'd0, V_FETCH_TMO);
    // SW with MemReady on the timeout cycle: completes normally
    cyc("swr_fetch",  1'b0, OP_SW, 1'b1, 4'd0, V_FETCH_GO);
    cyc("swr_decode", 1'b0, OP_SW, 1'b1, 4'd1, V_DECODE);
    cyc("swr_adr",    1'b0, OP_SW, 1'b0, 4'd2, V_MEMADR);
    cyc("swr_wr0",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc("swr_wr1",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc("swr_wr2",    1'b0, OP_SW, 1'b0, 4'd5, V_MEMWR_WAIT);
    cyc("swr_done",   1'b0, OP_SW, 1'b1, 4'd5, V_MEMWR_DONE);
    // Reset asserted mid-cycle while in MEMRD
    cyc("rr_fetch0",   1'b0, OP_LW, 1'b1, 4'd0, V_FETCH_GO);
    cyc("rr_decode0",  1'b0, OP_LW, 1'b1, 4'd1, V_DECODE);
    cyc("rr_adr",      1'b0, OP_LW, 1'b0, 4'd2, V_MEMADR);
    cyc("rr_rd",       1'b0, OP_LW, 1'b0, 4'd3, V_MEMRD);
    cyc("rr_rst",      1'b1, OP_LW, 1'b0, 4'd0, V_ZERO);
    cyc("rr_hold",     1'b1, OP_LW, 1'b1, 4'd0, V_ZERO);
    cyc("rr_fetch",    1'b0, OP_R,  1'b0, 4'd0, V_FETCH_WAIT);
    cyc("rr_fetch_go", 1'b0, OP_R,  1'b1, 4'd0, V_FETCH_GO);
    cyc("rr_decode",   1'b0, OP_R,  1'b1, 4'd1, V_DECODE);
    stim_done = 1'b1;
  end

  // Monitor: one queued expectation per cycle, compared on the falling edge.
  initial begin : monitor
    exp_t e;
    int   cycles;
    cycles = 0;
    while (!(stim_done && (sb.size() == 0)) && (cycles < 2000)) begin
      @(negedge Clk);
      cycles++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.nm, ".state"},   {14'd0, st1}, {14'd0, e.s1}, M_ALL);
        chk({e.nm, ".ctrl"},    act1,         e.v1,          e.m);
        chk({e.nm, ".state_b"}, {14'd0, st2}, {14'd0, e.s2}, M_ALL);
        chk({e.nm, ".ctrl_b"},  act2,         e.v2,          e.m);
      end
    end
    if (cycles >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL watchdog got %0d cycles want under 2000", cycles);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
